i2c_master_uc: RTL

//  Single-master I2C controller upstream of the slave control unit on the shared Sda/Scl bus.

---
 rtl/i2c_master_uc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_uc.sv
// Single-master I2C controller: START, LSB-first address and R/W bit, data bytes with ACK/NACK, STOP.
// Each bus bit spans four quarters; Sda changes after q0 and is sampled after q2.
module i2c_master_uc #(
    parameter int ADDRESSLENGTH = 7,
    parameter int QUARTER       = 125
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    inout  wire                      Sda,
    output logic                     Scl,
    input  logic                     Start,
    input  logic [ADDRESSLENGTH-1:0] Address,
    input  logic                     RorW,
    input  logic [7:0]               ByteCount,
    input  logic [7:0]               TxData,
    output logic                     TxLoad,
    output logic [7:0]               RxData,
    output logic                     RxValid,
    output logic                     Busy,
    output logic                     Done,
    output logic                     AckError
);

    localparam int QW = (QUARTER > 2) ? $clog2(QUARTER) : 1;
    localparam int BW = (ADDRESSLENGTH > 8) ? $clog2(ADDRESSLENGTH) : 3;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);
    localparam logic [BW-1:0] ALAST = BW'(ADDRESSLENGTH - 1);
    localparam logic [BW-1:0] DLAST = BW'(7);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, RW, ADDR_ACK, DATA, DATA_ACK, STOP
    } state_e;

    state_e                   state_q;
    logic [QW-1:0]            qcnt_q;
    logic [1:0]               ph_q;
    logic [BW-1:0]            bit_q;
    logic [7:0]               bytes_q;
    logic [ADDRESSLENGTH-1:0] addr_sh_q;
    logic                     rorw_q;
    logic [7:0]               tx_sh_q;
    logic [7:0]               rx_sh_q;
    logic [7:0]               rxdata_q;
    logic                     scl_q;
    logic                     sda_oe_q;
    logic                     sda_s1_q;
    logic                     sda_s2_q;
    logic                     ack_q;
    logic                     free_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     txload_q;
    logic                     rxvalid_q;
    logic                     err_q;
    logic                     more_bytes;
    logic                     bit_state;

    assign Sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign Scl      = scl_q;
    assign TxLoad   = txload_q;
    assign RxData   = rxdata_q;
    assign RxValid  = rxvalid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign AckError = err_q;

    assign more_bytes = bytes_q > 8'd1;
    assign bit_state  = (state_q == ADDR) || (state_q == RW) || (state_q == ADDR_ACK) ||
                        (state_q == DATA) || (state_q == DATA_ACK);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            ph_q      <= '0;
            bit_q     <= '0;
            bytes_q   <= '0;
            addr_sh_q <= '0;
            rorw_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rxdata_q  <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            ack_q     <= 1'b0;
            free_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            txload_q  <= 1'b0;
            rxvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sda_s1_q  <= Sda;
            sda_s2_q  <= sda_s1_q;
            txload_q  <= 1'b0;
            rxvalid_q <= 1'b0;
            done_q    <= 1'b0;
            // The captured write byte is taken in the cycle the load pulse is visible to the host.
            if (txload_q) tx_sh_q <= TxData;

            if (state_q == IDLE) begin
                if (Start) begin
                    state_q   <= START;
                    qcnt_q    <= '0;
                    ph_q      <= '0;
                    bit_q     <= '0;
                    addr_sh_q <= Address;
                    rorw_q    <= RorW;
                    bytes_q   <= ByteCount;
                    busy_q    <= 1'b1;
                    err_q     <= 1'b0;
                    free_q    <= 1'b0;
                    txload_q  <= RorW && (ByteCount != 8'd0);
                end
            end else if (qcnt_q != QLAST) begin
                qcnt_q <= qcnt_q + 1'b1;
            end else begin
                qcnt_q <= '0;
                ph_q   <= ph_q + 2'd1;
                if (bit_state) begin
                    if (ph_q == 2'd1) scl_q <= 1'b1;
                    if (ph_q == 2'd3) scl_q <= 1'b0;
                end
                case (state_q)
                    START: begin
                        if (ph_q == 2'd0) sda_oe_q <= 1'b1;
                        if (ph_q == 2'd2) begin
                            state_q <= ADDR;
                            ph_q    <= '0;
                            scl_q   <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (ph_q == 2'd0) sda_oe_q <= ~addr_sh_q[0];
                        if (ph_q == 2'd3) begin
                            addr_sh_q <= addr_sh_q >> 1;
                            if (bit_q == ALAST) begin
                                bit_q   <= '0;
                                state_q <= RW;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    RW: begin
                        if (ph_q == 2'd0) sda_oe_q <= ~rorw_q;
                        if (ph_q == 2'd3) state_q <= ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        if (ph_q == 2'd0) sda_oe_q <= 1'b0;
                        if (ph_q == 2'd2) ack_q <= sda_s2_q;
                        if (ph_q == 2'd3) begin
                            if (ack_q) begin
                                err_q   <= 1'b1;
                                state_q <= STOP;
                            end else if (bytes_q == 8'd0) begin
                                state_q <= STOP;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (ph_q == 2'd0) sda_oe_q <= rorw_q ? ~tx_sh_q[0] : 1'b0;
                        if (ph_q == 2'd2 && !rorw_q) begin
                            rx_sh_q <= {sda_s2_q, rx_sh_q[7:1]};
                            if (bit_q == DLAST) begin
                                rxdata_q  <= {sda_s2_q, rx_sh_q[7:1]};
                                rxvalid_q <= 1'b1;
                            end
                        end
                        if (ph_q == 2'd3) begin
                            if (rorw_q) tx_sh_q <= tx_sh_q >> 1;
                            if (bit_q == DLAST) begin
                                bit_q   <= '0;
                                state_q <= DATA_ACK;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    DATA_ACK: begin
                        if (ph_q == 2'd0) sda_oe_q <= rorw_q ? 1'b0 : more_bytes;
                        if (ph_q == 2'd2) ack_q <= sda_s2_q;
                        if (ph_q == 2'd3) begin
                            if (bytes_q != 8'd0) bytes_q <= bytes_q - 8'd1;
                            if (rorw_q && ack_q) begin
                                err_q   <= 1'b1;
                                state_q <= STOP;
                            end else if (more_bytes) begin
                                txload_q <= rorw_q;
                                state_q  <= DATA;
                            end else begin
                                state_q <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        // Four quarters of stop bit, then one extra bus-free quarter tracked by free_q.
                        if (free_q) begin
                            free_q  <= 1'b0;
                            ph_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            if (ph_q == 2'd0) sda_oe_q <= 1'b1;
                            if (ph_q == 2'd1) scl_q <= 1'b1;
                            if (ph_q == 2'd3) begin
                                sda_oe_q <= 1'b0;
                                free_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
